// File: rtl/wb_gpio_debounced.sv
// Wishbone-classic GPIO: per-pin input synchroniser, optional debounce, output enable, edge IRQs with W1C status.
// Build option: define GPIO_DEBOUNCE_EN to add per-pin debounce counters (otherwise the synchronised level is used directly).
module wb_gpio_debounced #(
  parameter int GPIO_WIDTH      = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 24000,
  parameter int CNT_W           = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  irq_o
);

  localparam int W = GPIO_WIDTH;

  generate
    if (GPIO_WIDTH < 1 || GPIO_WIDTH > 32) begin : g_bad_width
      $error("GPIO_WIDTH must be 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2 || (longint'(1) << CNT_W) <= longint'(DEBOUNCE_CYCLES)) begin : g_bad_deb
      $error("DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
    end
  endgenerate

  logic [SYNC_STAGES-1:0][W-1:0] sync_ff;
  logic [W-1:0] sync;
  logic [W-1:0] stable;
  logic [W-1:0] stable_d;

  logic [W-1:0] data_out;
  logic [W-1:0] dir;
  logic [W-1:0] irq_en;
  logic [W-1:0] irq_status;
  logic [W-1:0] edge_sel;

  logic         req;
  logic         wr;
  logic [2:0]   adr;
  logic [31:0]  wmask;
  logic [W-1:0] wmask_w;
  logic [W-1:0] wdat;
  logic [W-1:0] w1c;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic [W-1:0] ev;
  logic [W-1:0] rd_w;
  logic         unused_ok;

  // sync_ff[0] takes the raw pin; the last stage is the metastability-safe level
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], gpio_i};
    end
  end

  assign sync = sync_ff[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0][CNT_W-1:0] cnt;

  // A pin must disagree with its accepted level for DEBOUNCE_CYCLES consecutive cycles to flip it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= '0;
    end else begin
      for (int n = 0; n < W; n++) begin
        if (sync[n] == stable[n]) begin
          cnt[n] <= '0;
        end else if (cnt[n] == CNT_LAST) begin
          stable[n] <= sync[n];
          cnt[n]    <= '0;
        end else begin
          cnt[n] <= cnt[n] + 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
    end else begin
      stable <= sync;
    end
  end
`endif

  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr      = req & wb_we_i;
  assign adr     = wb_adr_i[4:2];
  assign wmask   = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wmask_w = wmask[W-1:0];
  assign wdat    = wb_dat_i[W-1:0];
  assign w1c     = (wr && adr == 3'd4) ? (wdat & wmask_w) : '0;

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;
  assign ev   = (edge_sel & rise) | (~edge_sel & fall);

  always_comb begin
    rd_w = '0;
    case (adr)
      3'd0:    rd_w = stable;
      3'd1:    rd_w = data_out;
      3'd2:    rd_w = dir;
      3'd3:    rd_w = irq_en;
      3'd4:    rd_w = irq_status;
      3'd5:    rd_w = edge_sel;
      default: rd_w = '0;
    endcase
  end

  function automatic logic [W-1:0] merge(input logic [W-1:0] old_v,
                                         input logic [W-1:0] new_v,
                                         input logic [W-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      data_out   <= '0;
      dir        <= '0;
      irq_en     <= '0;
      irq_status <= '0;
      edge_sel   <= '0;
      stable_d   <= '0;
    end else begin
      wb_ack_o <= req;
      stable_d <= stable;
      if (req) begin
        wb_dat_o <= 32'(rd_w);
      end
      if (wr) begin
        case (adr)
          3'd1:    data_out <= merge(data_out, wdat, wmask_w);
          3'd2:    dir      <= merge(dir, wdat, wmask_w);
          3'd3:    irq_en   <= merge(irq_en, wdat, wmask_w);
          3'd5:    edge_sel <= merge(edge_sel, wdat, wmask_w);
          default: ;
        endcase
      end
      // a new event outranks a clear landing in the same cycle
      irq_status <= (irq_status & ~w1c) | ev;
    end
  end

  assign gpio_o    = data_out;
  assign gpio_oe_o = dir;
  assign irq_o     = |(irq_status & irq_en);

  assign unused_ok = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i, wmask};

endmodule

// File: tb/tb_wb_gpio_debounced.sv
// Self-checking bench for wb_gpio_debounced: directed scenarios plus randomized pin/bus traffic against a window-based model.
module tb_wb_gpio_debounced;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HD   = SYNC + DEB;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = SYNC + DEB;
`else
  localparam int LAT = SYNC + 1;
`endif

  logic          clock;
  logic          reset_n;
  logic [31:0]   wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic [W-1:0]  gpio_i;
  logic [W-1:0]  gpio_o;
  logic [W-1:0]  gpio_oe_o;
  logic          irq_o;

  int checks;
  int errors;

  wb_gpio_debounced #(
    .GPIO_WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(3)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o), .irq_o(irq_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a level is accepted once the pin has shown it in every one of the
  // last DEB samples (SYNC cycles ago); registers follow the documented bus rules.
  logic [W-1:0] m_hist [HD];
  logic [W-1:0] m_stable, m_stable_d, m_out, m_dir, m_en, m_status, m_edge;
  logic         m_ack, m_req, m_wr, m_agree;
  logic [2:0]   m_adr;
  logic [W-1:0] m_wmask, m_w1c, m_ev, m_next_stable;

  always_comb begin
    m_req         = wb_cyc_i & wb_stb_i & ~m_ack;
    m_wr          = m_req & wb_we_i;
    m_adr         = wb_adr_i[4:2];
    m_wmask       = {W{wb_sel_i[0]}};
    m_w1c         = (m_wr && m_adr == 3'd4) ? (wb_dat_i[W-1:0] & m_wmask) : '0;
    m_ev          = (m_edge & m_stable & ~m_stable_d) | (~m_edge & ~m_stable & m_stable_d);
    m_next_stable = m_stable;
    m_agree       = 1'b0;
    for (int b = 0; b < W; b++) begin
`ifdef GPIO_DEBOUNCE_EN
      m_agree = 1'b1;
      for (int k = SYNC - 1; k <= HD - 2; k++) begin
        if (m_hist[k][b] != m_hist[SYNC-1][b]) m_agree = 1'b0;
      end
      if (m_agree) m_next_stable[b] = m_hist[SYNC-1][b];
`else
      m_next_stable[b] = m_hist[SYNC-1][b];
`endif
    end
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < HD; k++) m_hist[k] <= '0;
      m_stable <= '0; m_stable_d <= '0; m_out <= '0; m_dir <= '0;
      m_en <= '0; m_status <= '0; m_edge <= '0; m_ack <= 1'b0;
    end else begin
      m_hist[0] <= gpio_i;
      for (int k = 1; k < HD; k++) m_hist[k] <= m_hist[k-1];
      m_stable   <= m_next_stable;
      m_stable_d <= m_stable;
      m_status   <= (m_status & ~m_w1c) | m_ev;
      m_ack      <= m_req;
      if (m_wr) begin
        case (m_adr)
          3'd1: m_out  <= (m_out  & ~m_wmask) | (wb_dat_i[W-1:0] & m_wmask);
          3'd2: m_dir  <= (m_dir  & ~m_wmask) | (wb_dat_i[W-1:0] & m_wmask);
          3'd3: m_en   <= (m_en   & ~m_wmask) | (wb_dat_i[W-1:0] & m_wmask);
          3'd5: m_edge <= (m_edge & ~m_wmask) | (wb_dat_i[W-1:0] & m_wmask);
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[4:2])
      3'd0:    return 32'(m_stable);
      3'd1:    return 32'(m_out);
      3'd2:    return 32'(m_dir);
      3'd3:    return 32'(m_en);
      3'd4:    return 32'(m_status);
      3'd5:    return 32'(m_edge);
      default: return 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    repeat (HD + 3) step();
  endtask

  // One access: request now, expect ack on the next edge, then idle one cycle.
  task automatic bus_cycle(input logic [31:0] a, input logic we, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rdat, output logic [31:0] rexp);
    rexp     = m_read(a);
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = sel; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    step();
    checks++;
    if (wb_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL ack_latency adr=%h: ack=%b, expected 1", a, wb_ack_o);
    end
    rdat     = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    step();
    checks++;
    if (wb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL ack_drop adr=%h: ack=%b, expected 0", a, wb_ack_o);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r, e;
    bus_cycle(a, 1'b1, d, sel, r, e);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] r, output logic [31:0] e);
    bus_cycle(a, 1'b0, 32'h0, 4'h0, r, e);
  endtask

  task automatic test_reset();
    logic [31:0] r, e;
    checks++;
    if ({gpio_o, gpio_oe_o, irq_o, wb_ack_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gpio_o=%h oe=%h irq=%b ack=%b, expected all 0", gpio_o, gpio_oe_o, irq_o, wb_ack_o);
    end
    for (int off = 0; off < 8; off++) begin
      bus_read(32'(off * 4), r, e);
      checks++;
      if (r !== 32'h0) begin
        errors++;
        $display("FAIL reset_read off=%0h: got %h, expected 00000000", off * 4, r);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] r, e;
    bus_write(32'h04, 32'h0000_00A5, 4'b0001);
    checks++;
    if (gpio_o !== 8'hA5) begin errors++; $display("FAIL data_out_write: gpio_o=%h, expected a5", gpio_o); end
    bus_write(32'h08, 32'h0000_000F, 4'b0001);
    checks++;
    if (gpio_oe_o !== 8'h0F) begin errors++; $display("FAIL dir_write: gpio_oe_o=%h, expected 0f", gpio_oe_o); end
    bus_write(32'h04, 32'h0000_00FF, 4'b0000);
    checks++;
    if (gpio_o !== 8'hA5) begin errors++; $display("FAIL sel_gating: gpio_o=%h, expected a5", gpio_o); end
    bus_write(32'h1C, 32'hFFFF_FFFF, 4'hF);
    bus_read(32'h18, r, e);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h, expected 00000000", r); end
    bus_write(32'h00, 32'hFFFF_FFFF, 4'hF);
    bus_read(32'h00, r, e);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL data_in_write_ignored: got %h, expected 00000000", r); end
    bus_write(32'h04, 32'hFFFF_FF5A, 4'hF);
    bus_read(32'h04, r, e);
    checks++;
    if (r !== 32'h0000_005A) begin errors++; $display("FAIL upper_bits_zero: got %h, expected 0000005a", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    e = 32'(m_out);
    wb_adr_i = 32'h04; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (wb_ack_o !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL b2b_ack cycle %0d: ack=%b, expected %b", i, wb_ack_o, (i % 2) == 0);
      end
      if ((i % 2) == 0) begin
        checks++;
        if (wb_dat_o !== e) begin errors++; $display("FAIL b2b_data cycle %0d: got %h, expected %h", i, wb_dat_o, e); end
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
  endtask

  task automatic test_debounce();
    logic [31:0] r, e;
    gpio_i[0] = 1'b1;
    repeat (3) step();
    gpio_i[0] = 1'b0;
    settle();
    bus_read(32'h00, r, e);
    checks++;
    if (r !== 32'h0 || r !== e) begin errors++; $display("FAIL glitch_data_in: got %h, expected 00000000 (model %h)", r, e); end
    bus_read(32'h10, r, e);
    checks++;
    if (r !== e) begin errors++; $display("FAIL glitch_status: got %h, expected %h", r, e); end
    bus_write(32'h10, 32'hFF, 4'hF);
    gpio_i[0] = 1'b1;
    repeat (LAT - 1) step();
    bus_read(32'h00, r, e);
    checks++;
    if (r !== 32'h0 || r !== e) begin errors++; $display("FAIL latency_early: got %h, expected 00000000 (model %h)", r, e); end
    gpio_i[0] = 1'b0;
    settle();
    gpio_i[0] = 1'b1;
    repeat (LAT) step();
    bus_read(32'h00, r, e);
    checks++;
    if (r !== 32'h1 || r !== e) begin errors++; $display("FAIL latency_exact: got %h, expected 00000001 (model %h)", r, e); end
    gpio_i[0] = 1'b0;
    settle();
    bus_write(32'h10, 32'hFF, 4'hF);
  endtask

  task automatic test_irq();
    logic [31:0] r, e;
    bus_write(32'h14, 32'h01, 4'hF);
    bus_write(32'h0C, 32'h01, 4'hF);
    gpio_i[0] = 1'b1;
    repeat (LAT + 2) step();
    bus_read(32'h10, r, e);
    checks++;
    if (r !== 32'h1 || irq_o !== 1'b1) begin errors++; $display("FAIL irq_rise: status=%h irq=%b, expected 00000001/1", r, irq_o); end
    bus_write(32'h10, 32'h01, 4'h1);
    bus_read(32'h10, r, e);
    checks++;
    if (r !== 32'h0 || irq_o !== 1'b0) begin errors++; $display("FAIL irq_w1c: status=%h irq=%b, expected 00000000/0", r, irq_o); end
    gpio_i[0] = 1'b0;
    repeat (LAT + 2) step();
    bus_read(32'h10, r, e);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL irq_fall_unselected: status=%h, expected 00000000", r); end
    bus_write(32'h0C, 32'h00, 4'hF);
    gpio_i[0] = 1'b1;
    repeat (LAT + 2) step();
    bus_read(32'h10, r, e);
    checks++;
    if (r !== 32'h1 || irq_o !== 1'b0) begin errors++; $display("FAIL irq_masked: status=%h irq=%b, expected 00000001/0", r, irq_o); end
    gpio_i[0] = 1'b0;
    settle();
  endtask

  task automatic test_w1c_collision();
    logic [31:0] r, e;
    bus_write(32'h0C, 32'h01, 4'hF);
    gpio_i[0] = 1'b1;
    repeat (LAT) step();
    bus_write(32'h10, 32'h01, 4'h1);
    checks++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL collision_irq: irq=%b, expected 1", irq_o); end
    bus_read(32'h10, r, e);
    checks++;
    if (r !== 32'h1 || r !== e) begin errors++; $display("FAIL collision_status: got %h, expected 00000001 (model %h)", r, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, e;
    bus_write(32'h04, 32'h3C, 4'hF);
    bus_write(32'h08, 32'hFF, 4'hF);
    gpio_i[0] = 1'b0;
    repeat (4) step();
    wb_adr_i = 32'h04; wb_dat_i = 32'h0; wb_sel_i = 4'hF; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({gpio_o, gpio_oe_o, irq_o, wb_ack_o} !== '0) begin
      errors++;
      $display("FAIL reset_async: gpio_o=%h oe=%h irq=%b ack=%b, expected all 0", gpio_o, gpio_oe_o, irq_o, wb_ack_o);
    end
    step();
    step();
    checks++;
    if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_no_ack: ack=%b, expected 0", wb_ack_o); end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    reset_n = 1'b1;
    step();
    step();
    gpio_i[0] = 1'b1;
    repeat (3) step();
    gpio_i[0] = 1'b0;
    settle();
    bus_read(32'h00, r, e);
    checks++;
    if (r !== e) begin errors++; $display("FAIL post_reset_pulse: data_in=%h, expected %h", r, e); end
    bus_read(32'h04, r, e);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL post_reset_data_out: got %h, expected 00000000", r); end
  endtask

  task automatic test_random();
    logic [31:0] r, e, a;
    int hold;
    hold = 0;
    bus_write(32'h14, 32'($urandom_range(0, 255)), 4'hF);
    bus_write(32'h0C, 32'($urandom_range(0, 255)), 4'hF);
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        gpio_i = gpio_i ^ W'($urandom_range(0, 255));
        hold   = $urandom_range(1, 9);
      end
      hold--;
      if (i % 7 == 0) begin
        a = 32'($urandom_range(0, 7) * 4);
        if ($urandom_range(0, 1) == 0) begin
          bus_read(a, r, e);
          checks++;
          if (r !== e) begin errors++; $display("FAIL rand_read adr=%h iter %0d: got %h, expected %h", a, i, r, e); end
        end else begin
          bus_write(a, $urandom, 4'($urandom_range(0, 15)));
        end
      end else begin
        step();
      end
      checks++;
      if (irq_o !== |(m_status & m_en) || gpio_o !== m_out || gpio_oe_o !== m_dir) begin
        errors++;
        $display("FAIL rand_outputs iter %0d: irq=%b gpio_o=%h oe=%h, expected %b %h %h",
                 i, irq_o, gpio_o, gpio_oe_o, |(m_status & m_en), m_out, m_dir);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; gpio_i = '0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    test_reset();
    test_regs();
    test_back_to_back();
    test_debounce();
    test_irq();
    test_w1c_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
